alu_issue_ctrl: RTL and testbench

// - Initiator side of the 32-bit ALU interface (src1/src2/ALU_control in; result/zero/cout/overflow out).
// - Accepts one operation per request over a valid/ready handshake: ALUOp, funct and two operands.
// - Decodes ALUOp/funct into the 4-bit ALU control code and drives the ALU for the required cycles.
// - Captures the ALU's registered flags and result, then returns them over a valid/ready response port.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_ctrl_dec.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU control codes,
// ALUOp/funct fields and the issue FSM state type.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_code_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } issue_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decoder producing the 4-bit ALU control code
// and an illegal flag for encodings the ALU does not implement.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = ALU_AND;
        illegal = 1'b0;
        unique case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_NOR: code = ALU_NOR;
                    FUNCT_SLT: code = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            ALUOP_ILL: illegal = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded operation at a time to a registered 32-bit ALU and
// returns the captured result and flags over a valid/ready response port.
//
// state  | meaning
// IDLE   | ready for a request; alu_* hold the last issued operation
// DRIVE  | operands/code held on the ALU for ALU_LAT cycles
// SAMPLE | ALU outputs valid; captured into out_*
// DONE   | response presented until out_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_aluop,
    input  logic [5:0]   in_funct,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,

    output logic [W-1:0] alu_src1,
    output logic [W-1:0] alu_src2,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_cout,
    input  logic         alu_overflow,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_zero,
    output logic         out_cout,
    output logic         out_overflow,
    output logic         out_illegal
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    issue_state_e state;
    logic [3:0]   cnt;
    logic [3:0]   dec_code;
    logic         dec_illegal;

    alu_ctrl_dec u_dec (
        .aluop   (in_aluop),
        .funct   (in_funct),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            in_ready     <= 1'b0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_ctrl     <= 4'b0000;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // in_ready is low only in the first cycle out of reset
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (!dec_illegal) begin
                            alu_src1 <= in_a;
                            alu_src2 <= in_b;
                            alu_ctrl <= dec_code;
                            cnt      <= CNT_INIT;
                            state    <= ST_DRIVE;
                        end else begin
                            out_result   <= '0;
                            out_zero     <= 1'b0;
                            out_cout     <= 1'b0;
                            out_overflow <= 1'b0;
                            out_illegal  <= 1'b1;
                            out_valid    <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    out_result   <= alu_result;
                    out_zero     <= alu_zero;
                    out_cout     <= alu_cout;
                    out_overflow <= alu_overflow;
                    out_illegal  <= 1'b0;
                    out_valid    <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered single-cycle ALU model
// and a queue of expected responses.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_aluop = '0;
    logic [5:0]  in_funct = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero, alu_cout, alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero, out_cout, out_overflow, out_illegal;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.W(32), .ALU_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluop     (in_aluop),
        .in_funct     (in_funct),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_illegal  (out_illegal)
    );

    // Registered ALU: outputs valid one clock after operands are applied.
    always @(posedge clk or negedge rst_n) begin
        logic [32:0] sum;
        if (!rst_n) begin
            alu_result   <= '0;
            alu_zero     <= 1'b0;
            alu_cout     <= 1'b0;
            alu_overflow <= 1'b0;
        end else begin
            sum = '0;
            case (alu_ctrl)
                4'b0010: sum = {1'b0, alu_src1} + {1'b0, alu_src2};
                4'b0110: sum = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
                4'b0000: sum = {1'b0, alu_src1 & alu_src2};
                4'b0001: sum = {1'b0, alu_src1 | alu_src2};
                4'b1100: sum = {1'b0, ~(alu_src1 | alu_src2)};
                4'b0111: sum = {32'd0, $signed(alu_src1) < $signed(alu_src2)};
                default: sum = '0;
            endcase
            alu_result <= sum[31:0];
            alu_zero   <= (sum[31:0] == 32'd0);
            alu_cout   <= (alu_ctrl == 4'b0010 || alu_ctrl == 4'b0110) ? sum[32] : 1'b0;
            if (alu_ctrl == 4'b0010)
                alu_overflow <= (alu_src1[31] == alu_src2[31]) && (sum[31] != alu_src1[31]);
            else if (alu_ctrl == 4'b0110)
                alu_overflow <= (alu_src1[31] != alu_src2[31]) && (sum[31] != alu_src1[31]);
            else
                alu_overflow <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ctrl, input logic [31:0] res,
                                input logic z, input logic c, input logic v, input logic ill);
        exp_t e;
        e.ctrl = ctrl; e.res = res; e.z = z; e.c = c; e.v = v; e.ill = ill;
        return e;
    endfunction

    // Drive one request, check issue, wait for the response, optionally hold
    // it under backpressure for `hold` cycles, then complete the handshake.
    task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int hold);
        int n;
        int lat;
        exp_t got;
        logic [3:0]  prev_ctrl;
        logic [31:0] prev_s1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 20), 32'd1);
        prev_ctrl = alu_ctrl;
        prev_s1   = alu_src1;
        in_aluop = op; in_funct = fn; in_a = a; in_b = b; in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_accepted"}, 32'(in_ready), 32'd0);
        if (!e.ill) begin
            check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
            check({tag, "_alu_src1"}, alu_src1, a);
            check({tag, "_alu_src2"}, alu_src2, b);
        end else begin
            check({tag, "_ctrl_held"}, 32'(alu_ctrl), 32'(prev_ctrl));
            check({tag, "_src1_held"}, alu_src1, prev_s1);
        end
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), e.ill ? 32'd1 : 32'd3);
        check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check({tag, "_result"},   out_result,          got.res);
            check({tag, "_zero"},     32'(out_zero),       32'(got.z));
            check({tag, "_cout"},     32'(out_cout),       32'(got.c));
            check({tag, "_overflow"}, 32'(out_overflow),   32'(got.v));
            check({tag, "_illegal"},  32'(out_illegal),    32'(got.ill));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"},  32'(out_valid), 32'd1);
                check({tag, "_hold_ready"},  32'(in_ready),  32'd0);
                check({tag, "_hold_result"}, out_result,     got.res);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        #2;
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
        check("rst_alu_src1",   alu_src1,        32'd0);
        check("rst_out_result", out_result,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("first_cycle_in_ready", 32'(in_ready), 32'd1);

        issue("add",      2'b10, 6'b100000, 32'd5,          32'd7,        mk(4'b0010, 32'd12,         0, 0, 0, 0), 0);
        issue("sub_ovf",  2'b01, 6'b000000, 32'h8000_0000,  32'd1,        mk(4'b0110, 32'h7FFF_FFFF,  0, 1, 1, 0), 0);
        issue("slt_lt",   2'b10, 6'b101010, 32'hFFFF_FFFD,  32'd2,        mk(4'b0111, 32'd1,          0, 0, 0, 0), 0);
        issue("slt_ge",   2'b10, 6'b101010, 32'd4,          32'd2,        mk(4'b0111, 32'd0,          1, 0, 0, 0), 0);
        issue("illegal",  2'b10, 6'b000000, 32'd9,          32'd9,        mk(4'b0000, 32'd0,          0, 0, 0, 1), 0);
        issue("and_bp",   2'b10, 6'b100100, 32'hF0F0_00FF,  32'h0FF0_0F0F, mk(4'b0000, 32'h00F0_000F, 0, 0, 0, 0), 5);
        issue("or",       2'b10, 6'b100101, 32'hF0F0_00FF,  32'h0FF0_0F0F, mk(4'b0001, 32'hFFF0_0FFF, 0, 0, 0, 0), 0);
        issue("nor",      2'b10, 6'b100111, 32'hF0F0_00FF,  32'h0FF0_0F0F, mk(4'b1100, 32'h000F_F000, 0, 0, 0, 0), 0);
        issue("ld_wrap",  2'b00, 6'b111111, 32'hFFFF_FFFF,  32'd1,        mk(4'b0010, 32'd0,          1, 1, 0, 0), 0);
        issue("sub_eq",   2'b10, 6'b100010, 32'd9,          32'd9,        mk(4'b0110, 32'd0,          1, 1, 0, 0), 0);
        issue("op11_ill", 2'b11, 6'b100000, 32'd1,          32'd1,        mk(4'b0000, 32'd0,          0, 0, 0, 1), 2);
        issue("add2",     2'b10, 6'b100000, 32'd5,          32'd7,        mk(4'b0010, 32'd12,         0, 0, 0, 0), 0);

        // Abandon an operation in DRIVE.
        in_aluop = 2'b01; in_funct = 6'b0; in_a = 32'd100; in_b = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midop_in_drive", 32'(alu_ctrl), 32'b0110);
        rst_n = 1'b0;
        #1;
        check("midop_in_ready",   32'(in_ready),   32'd0);
        check("midop_out_valid",  32'(out_valid),  32'd0);
        check("midop_alu_ctrl",   32'(alu_ctrl),   32'd0);
        check("midop_alu_src1",   alu_src1,        32'd0);
        check("midop_alu_src2",   alu_src2,        32'd0);
        check("midop_out_result", out_result,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midop_no_response", 32'(out_valid), 32'd0);
        end
        check("midop_ready_after", 32'(in_ready), 32'd1);

        issue("post_rst", 2'b10, 6'b100000, 32'd1, 32'd2, mk(4'b0010, 32'd3, 0, 0, 0, 0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
